// File: rtl/rs_enc.sv
// ---------------------------------------------------------------------------
// rs_enc -- systematic Reed-Solomon encoder, one symbol per clock.
//
// Message symbols (highest-degree coefficient first) pass straight through to
// the output. After K_LEN of them, the ROOTS_NUM parity symbols
// (m(x)*x^ROOTS_NUM mod g(x)) are appended, highest degree first.
// g(x) = prod_{i=0..ROOTS_NUM-1} (x + alpha^(FIRST_ROOT+i)) is expanded at
// elaboration time, so every GF multiply in the datapath has a constant
// operand.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   s_tvalid   input symbol valid
//   s_tready   encoder can take an input symbol
//   s_tdata    message symbol
//   s_tlast    sender's end-of-message marker (checked only, never obeyed)
//   m_tvalid   output symbol valid
//   m_tready   downstream takes the output symbol
//   m_tdata    codeword symbol
//   m_tlast    marks the final parity symbol of a codeword
//   err_tlast  one-cycle pulse when s_tlast disagrees with the symbol count
//
// Handshake: a symbol moves on a rising edge where valid && ready. Once
// m_tvalid is high, m_tdata/m_tlast are held until m_tready. s_tready is
// derived from state and m_tready only; it never looks at s_tvalid.
// ---------------------------------------------------------------------------
module rs_enc #(
  parameter int SYMB_WIDTH = 8,
  parameter int POLY       = 285,
  parameter int N_LEN      = 255,
  parameter int K_LEN      = 239,
  parameter int FIRST_ROOT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [SYMB_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  err_tlast
);

  localparam int W   = SYMB_WIDTH;
  localparam int R   = N_LEN - K_LEN;
  localparam int MCW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int PCW = (R > 1) ? $clog2(R) : 1;

  localparam logic [MCW-1:0] MSG_LAST = MCW'(K_LEN - 1);
  localparam logic [PCW-1:0] PAR_LAST = PCW'(R - 1);
  localparam logic [W-1:0]   POLY_LO  = W'(POLY);

  // Shift-and-add GF(2^W) multiply. With one constant operand it reduces to
  // a small XOR network.
  function automatic logic [W-1:0] gf_mult(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] acc;
    logic [W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[W-1] ? ((sh << 1) ^ POLY_LO) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] gf_pow(input int e);
    logic [W-1:0] r;
    r = W'(1);
    for (int i = 0; i < e; i++) r = gf_mult(r, W'(2));
    return r;
  endfunction

  // Low-order coefficients g[0..R-1] packed LSB-first; g[R] = 1 is implied.
  function automatic logic [R*W-1:0] gen_coefs();
    logic [W-1:0]   c [0:R];
    logic [W-1:0]   root;
    logic [R*W-1:0] res;
    for (int j = 0; j <= R; j++) c[j] = '0;
    c[0] = W'(1);
    for (int i = 0; i < R; i++) begin
      root = gf_pow(FIRST_ROOT + i);
      for (int j = R; j >= 1; j--) c[j] = c[j-1] ^ gf_mult(root, c[j]);
      c[0] = gf_mult(root, c[0]);
    end
    res = '0;
    for (int j = 0; j < R; j++) res[j*W +: W] = c[j];
    return res;
  endfunction

  localparam logic [R*W-1:0] G_COEF = gen_coefs();

  typedef enum logic {
    ST_MSG    = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  state_t         state_q;
  logic [MCW-1:0] msg_cnt_q;
  logic [PCW-1:0] par_cnt_q;
  logic [W-1:0]   par_q [R];
  logic [W-1:0]   par_fb_d [R];
  logic [W-1:0]   dat_q;
  logic           vld_q;
  logic           last_q;
  logic           err_q;

  logic           out_free;
  logic           s_fire;
  logic           msg_last;
  logic [W-1:0]   fb;

  assign out_free = !vld_q || m_tready;
  assign s_tready = !rst && (state_q == ST_MSG) && out_free;
  assign s_fire   = s_tvalid && s_tready;
  assign msg_last = (msg_cnt_q == MSG_LAST);
  assign fb       = s_tdata ^ par_q[R-1];

  // Next remainder when a message symbol is absorbed (division LFSR step).
  always_comb begin
    par_fb_d = '{default: '0};
    par_fb_d[0] = gf_mult(G_COEF[0 +: W], fb);
    for (int i = 1; i < R; i++) begin
      par_fb_d[i] = par_q[i-1] ^ gf_mult(G_COEF[i*W +: W], fb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MSG;
      msg_cnt_q <= '0;
      par_cnt_q <= '0;
      par_q     <= '{default: '0};
      dat_q     <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_MSG: begin
          if (s_fire) begin
            par_q  <= par_fb_d;
            dat_q  <= s_tdata;
            vld_q  <= 1'b1;
            last_q <= 1'b0;
            // Framing is judged against the counter; s_tlast is advisory.
            err_q  <= s_tlast ^ msg_last;
            if (msg_last) begin
              msg_cnt_q <= '0;
              state_q   <= ST_PARITY;
            end else begin
              msg_cnt_q <= msg_cnt_q + MCW'(1);
            end
          end else if (out_free) begin
            vld_q <= 1'b0;
          end
        end
        ST_PARITY: begin
          if (out_free) begin
            dat_q  <= par_q[R-1];
            vld_q  <= 1'b1;
            last_q <= (par_cnt_q == PAR_LAST);
            // Shifting zeros in leaves par all-zero for the next codeword.
            for (int i = R - 1; i >= 1; i--) par_q[i] <= par_q[i-1];
            par_q[0] <= '0;
            if (par_cnt_q == PAR_LAST) begin
              par_cnt_q <= '0;
              state_q   <= ST_MSG;
            end else begin
              par_cnt_q <= par_cnt_q + PCW'(1);
            end
          end
        end
        default: state_q <= ST_MSG;
      endcase
    end
  end

  assign m_tvalid  = vld_q;
  assign m_tdata   = dat_q;
  assign m_tlast   = last_q;
  assign err_tlast = err_q;

endmodule

// File: tb/tb_rs_enc.sv
// ---------------------------------------------------------------------------
// tb_rs_enc -- bench for rs_enc. A (255,239) instance carries the main
// traffic; a (6,4) instance checks small hand-computable codewords.
// The reference encoder is table-driven GF arithmetic plus textbook
// polynomial long division; codewords are also checked for zero syndromes.
// ---------------------------------------------------------------------------
module tb_rs_enc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       big_rst, big_s_tvalid, big_s_tready, big_s_tlast;
  logic [7:0] big_s_tdata, big_m_tdata;
  logic       big_m_tvalid, big_m_tready, big_m_tlast, big_err_tlast;

  logic       sml_rst, sml_s_tvalid, sml_s_tready, sml_s_tlast;
  logic [7:0] sml_s_tdata, sml_m_tdata;
  logic       sml_m_tvalid, sml_m_tready, sml_m_tlast, sml_err_tlast;

  rs_enc dut_big (
    .clk(clk), .rst(big_rst),
    .s_tvalid(big_s_tvalid), .s_tready(big_s_tready),
    .s_tdata(big_s_tdata), .s_tlast(big_s_tlast),
    .m_tvalid(big_m_tvalid), .m_tready(big_m_tready),
    .m_tdata(big_m_tdata), .m_tlast(big_m_tlast),
    .err_tlast(big_err_tlast)
  );

  rs_enc #(.N_LEN(6), .K_LEN(4), .FIRST_ROOT(1)) dut_sml (
    .clk(clk), .rst(sml_rst),
    .s_tvalid(sml_s_tvalid), .s_tready(sml_s_tready),
    .s_tdata(sml_s_tdata), .s_tlast(sml_s_tlast),
    .m_tvalid(sml_m_tvalid), .m_tready(sml_m_tready),
    .m_tdata(sml_m_tdata), .m_tlast(sml_m_tlast),
    .err_tlast(sml_err_tlast)
  );

  // ---------------- checking ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_t [0:509];
  logic [7:0] log_t [0:255];
  logic [7:0] gen_c [0:16];   // generator, highest degree first, gen_c[0] = 1
  logic [7:0] msg_buf [0:254];
  logic [7:0] cw_buf  [0:254];
  logic [7:0] dv      [0:254];

  task automatic init_gf();
    logic [8:0] x;
    x = 9'd1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]       = x[7:0];
      exp_t[i + 255] = x[7:0];
      log_t[x[7:0]]  = 8'(i);
      x = x << 1;
      if (x[8]) x = x ^ 9'd285;
    end
    log_t[0] = 8'd0;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'd0 || b == 8'd0) return 8'd0;
    return exp_t[int'(log_t[a]) + int'(log_t[b])];
  endfunction

  task automatic build_gen(input int nr);
    logic [7:0] root;
    gen_c[0] = 8'd1;
    for (int j = 1; j <= 16; j++) gen_c[j] = 8'd0;
    for (int r = 0; r < nr; r++) begin
      root = exp_t[1 + r];
      for (int j = r + 1; j >= 1; j--) gen_c[j] = gen_c[j] ^ gmul(root, gen_c[j-1]);
    end
  endtask

  // Long division of m(x)*x^nr by g(x); codeword = message then remainder.
  task automatic model_encode(input int k, input int nr);
    logic [7:0] coef;
    for (int i = 0; i < k; i++) dv[i] = msg_buf[i];
    for (int i = k; i < k + nr; i++) dv[i] = 8'd0;
    for (int i = 0; i < k; i++) begin
      coef = dv[i];
      for (int j = 1; j <= nr; j++) dv[i+j] = dv[i+j] ^ gmul(coef, gen_c[j]);
    end
    for (int i = 0; i < k; i++) cw_buf[i] = msg_buf[i];
    for (int i = k; i < k + nr; i++) cw_buf[i] = dv[i];
  endtask

  // ---------------- big-instance driver / scoreboard ----------------
  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] d;
  } src_t;

  src_t       src_q[$];
  src_t       saved_src[$];
  logic [8:0] exp_q[$];
  logic [8:0] saved_exp[$];

  logic       stall_mode = 1'b0;
  logic       pending    = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d     = 8'd0;
  logic       prev_l     = 1'b0;
  logic [7:0] cw_got [0:254];
  int         cw_pos     = 0;
  int         unexpected = 0;
  int         err_cnt    = 0;
  int         ins        = 0;
  int         outs       = 0;

  function automatic logic [7:0] eval_at(input int e);
    logic [7:0] s;
    s = 8'd0;
    for (int j = 0; j < 255; j++) s = gmul(s, exp_t[e]) ^ cw_got[j];
    return s;
  endfunction

  task automatic check_syndromes();
    for (int i = 1; i <= 16; i++) chk("syndrome", 32'(eval_at(i)), 32'd0);
  endtask

  task automatic queue_msg(input int kind, input int bad_idx);
    src_t s;
    build_gen(16);
    for (int i = 0; i < 239; i++) begin
      msg_buf[i] = (kind == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      s.d    = msg_buf[i];
      s.last = (i == 238) || (i == bad_idx);
      s.err  = s.last != (i == 238);
      src_q.push_back(s);
    end
    model_encode(239, 16);
    for (int i = 0; i < 255; i++) exp_q.push_back({(i == 254), cw_buf[i]});
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic tick();
    src_t       cur;
    logic       in_fire, out_fire, ol;
    logic [7:0] od;
    logic [8:0] e;
    big_m_tready = stall_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    if (!pending) begin
      if (src_q.size() > 0 && (!stall_mode || $urandom_range(0, 1) == 1)) begin
        cur          = src_q[0];
        big_s_tvalid = 1'b1;
        big_s_tdata  = cur.d;
        big_s_tlast  = cur.last;
        pending      = 1'b1;
      end else begin
        big_s_tvalid = 1'b0;
        big_s_tdata  = 8'($urandom_range(0, 255));
        big_s_tlast  = 1'($urandom_range(0, 1));
      end
    end
    #1;
    if (prev_stall) begin
      chk("hold_valid", 32'(big_m_tvalid), 32'd1);
      chk("hold_data", 32'(big_m_tdata), 32'(prev_d));
      chk("hold_last", 32'(big_m_tlast), 32'(prev_l));
    end
    in_fire    = big_s_tvalid && big_s_tready;
    out_fire   = big_m_tvalid && big_m_tready;
    od         = big_m_tdata;
    ol         = big_m_tlast;
    prev_stall = big_m_tvalid && !big_m_tready;
    prev_d     = od;
    prev_l     = ol;
    cur        = '0;
    if (src_q.size() > 0) cur = src_q[0];
    @(posedge clk);
    @(negedge clk);
    if (in_fire) begin
      void'(src_q.pop_front());
      pending = 1'b0;
      ins++;
    end
    if (big_err_tlast === 1'b1) err_cnt++;
    chk("err_tlast", 32'(big_err_tlast), 32'(in_fire && cur.err));
    if (out_fire) begin
      outs++;
      if (exp_q.size() == 0) begin
        unexpected++;
      end else begin
        e = exp_q.pop_front();
        chk("m_tdata", 32'(od), 32'(e[7:0]));
        chk("m_tlast", 32'(ol), 32'(e[8]));
      end
      cw_got[cw_pos] = od;
      cw_pos++;
      if (cw_pos == 255) begin
        check_syndromes();
        cw_pos = 0;
      end
    end
  endtask

  task automatic run(input int stop_in, input int stop_out, input int budget,
                     output int ticks);
    ticks = 0;
    ins   = 0;
    outs  = 0;
    while (exp_q.size() > 0 && ticks < budget &&
           !(stop_in >= 0 && ins >= stop_in) &&
           !(stop_out >= 0 && outs >= stop_out)) begin
      tick();
      ticks++;
    end
    if (stop_in < 0 && stop_out < 0) begin
      chk("run_drained", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("no_extra_output", 32'(unexpected), 32'd0);
    end
  endtask

  task automatic do_reset();
    big_rst      = 1'b1;
    big_s_tvalid = 1'b0;
    pending      = 1'b0;
    prev_stall   = 1'b0;
    src_q.delete();
    exp_q.delete();
    cw_pos = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 32'(big_m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(big_m_tdata), 32'd0);
    chk("rst_m_tlast", 32'(big_m_tlast), 32'd0);
    chk("rst_err_tlast", 32'(big_err_tlast), 32'd0);
    chk("rst_s_tready", 32'(big_s_tready), 32'd0);
    big_rst = 1'b0;
  endtask

  // ---------------- small-instance driver ----------------
  task automatic sml_run(input logic [31:0] msg, input logic [47:0] expv);
    int         idx, oc;
    logic       inf, outf, ol;
    logic [7:0] od;
    idx = 0;
    oc  = 0;
    for (int c = 0; c < 30 && oc < 6; c++) begin
      sml_m_tready = 1'b1;
      if (idx < 4) begin
        sml_s_tvalid = 1'b1;
        sml_s_tdata  = msg[31 - 8*idx -: 8];
        sml_s_tlast  = (idx == 3);
      end else begin
        sml_s_tvalid = 1'b0;
      end
      #1;
      inf  = sml_s_tvalid && sml_s_tready;
      outf = sml_m_tvalid && sml_m_tready;
      od   = sml_m_tdata;
      ol   = sml_m_tlast;
      @(posedge clk);
      @(negedge clk);
      if (inf) idx++;
      chk("sml_err_tlast", 32'(sml_err_tlast), 32'd0);
      if (outf) begin
        chk("sml_m_tdata", 32'(od), 32'(expv[47 - 8*oc -: 8]));
        chk("sml_m_tlast", 32'(ol), 32'(oc == 5));
        oc++;
      end
    end
    chk("sml_symbol_count", 32'(oc), 32'd6);
    sml_s_tvalid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         t;
    logic [47:0] sml_exp;

    init_gf();
    big_rst = 1'b1; big_s_tvalid = 1'b0; big_s_tdata = 8'd0; big_s_tlast = 1'b0;
    big_m_tready = 1'b1;
    sml_rst = 1'b1; sml_s_tvalid = 1'b0; sml_s_tdata = 8'd0; sml_s_tlast = 1'b0;
    sml_m_tready = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("reset_m_tvalid", 32'(big_m_tvalid), 32'd0);
    chk("reset_m_tdata", 32'(big_m_tdata), 32'd0);
    chk("reset_m_tlast", 32'(big_m_tlast), 32'd0);
    chk("reset_err_tlast", 32'(big_err_tlast), 32'd0);
    chk("reset_s_tready", 32'(big_s_tready), 32'd0);
    chk("sml_reset_m_tvalid", 32'(sml_m_tvalid), 32'd0);
    chk("sml_reset_s_tready", 32'(sml_s_tready), 32'd0);
    big_rst = 1'b0;
    sml_rst = 1'b0;
    #1;
    chk("idle_s_tready", 32'(big_s_tready), 32'd1);

    // (6,4) code, g = x^2 + 6x + 8: message [0,0,0,1] -> 0,0,0,1,6,8
    sml_run(32'h0000_0001, 48'h0000_0001_0608);
    // message [1,0,0,0]: parity = x^5 mod g from the model
    build_gen(2);
    msg_buf[0] = 8'd1; msg_buf[1] = 8'd0; msg_buf[2] = 8'd0; msg_buf[3] = 8'd0;
    model_encode(4, 2);
    sml_exp = {cw_buf[0], cw_buf[1], cw_buf[2], cw_buf[3], cw_buf[4], cw_buf[5]};
    sml_run(32'h0100_0000, sml_exp);

    // All-zero message, no backpressure
    stall_mode = 1'b0;
    queue_msg(0, -1);
    run(-1, -1, 2000, t);

    // Two random codewords back to back: full rate, no bubbles
    queue_msg(1, -1);
    queue_msg(1, -1);
    saved_src = src_q;
    saved_exp = exp_q;
    run(-1, -1, 2000, t);
    chk("back_to_back_cycles", 32'(t), 32'd511);

    // Same stream with random output stalls and input gaps
    src_q      = saved_src;
    exp_q      = saved_exp;
    stall_mode = 1'b1;
    run(-1, -1, 8000, t);
    stall_mode = 1'b0;

    // Early s_tlast on symbol #100: exactly one err pulse, framing unchanged
    err_cnt = 0;
    queue_msg(1, 99);
    run(-1, -1, 2000, t);
    chk("err_pulse_count", 32'(err_cnt), 32'd1);

    // Reset at message symbol #50, then an all-zero codeword
    queue_msg(1, -1);
    run(50, -1, 2000, t);
    do_reset();
    queue_msg(0, -1);
    run(-1, -1, 2000, t);

    // Reset after parity #5, then an all-zero codeword
    queue_msg(1, -1);
    run(-1, 244, 2000, t);
    do_reset();
    queue_msg(0, -1);
    run(-1, -1, 2000, t);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_enc.md
Name: rs_enc

Overview:
- Systematic Reed-Solomon encoder, one symbol per cycle. It is the transmit-side counterpart of the RS decoder chain (syndrome, BM, Chien, Forney) and shares the gf_pkg field arithmetic.
- It accepts K_LEN message symbols and passes them through unchanged. It then appends ROOTS_NUM parity symbols, the remainder of m(x)·x^ROOTS_NUM mod g(x).
- The generator is g(x) = prod over i = 0..ROOTS_NUM-1 of (x + α^(FIRST_ROOT+i)). Its coefficients are computed at elaboration with gf_pkg constant functions.

Parameters:
- SYMB_WIDTH, 8, symbol width in bits.
- POLY, 285, field primitive polynomial.
- N_LEN, 255, codeword length in symbols.
- K_LEN, 239, message length in symbols; ROOTS_NUM = N_LEN - K_LEN must be ≥ 2.
- FIRST_ROOT, 1, exponent of the first generator root.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_tvalid  in  1  input symbol valid.
- s_tready  out  1  encoder accepts an input symbol.
- s_tdata  in  SYMB_WIDTH  message symbol, highest-degree coefficient first.
- s_tlast  in  1  marks the K_LEN-th message symbol.
- m_tvalid  out  1  output symbol valid.
- m_tready  in  1  downstream accepts an output symbol.
- m_tdata  out  SYMB_WIDTH  codeword symbol.
- m_tlast  out  1  marks the final parity symbol.
- err_tlast  out  1  one-cycle pulse on a framing mismatch.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset state: state = MSG, msg_cnt = 0, par_cnt = 0, parity register par[ROOTS_NUM-1:0] = 0, output register empty.
- Outputs in reset: m_tvalid = 0, m_tdata = 0, m_tlast = 0, err_tlast = 0, s_tready = 0 while rst = 1.
- Handshakes: a transfer occurs when valid && ready on the same edge. The output register is free when !m_tvalid || m_tready.
- s_tready = (state == MSG) && output register free. It is combinational from state and m_tready; there is no comb path from s_tvalid.
- MSG state, on an accepted symbol d:
  - fb = d ^ par[ROOTS_NUM-1].
  - par[i] <= par[i-1] ^ gf_mult(g[i], fb) for i ≥ 1; par[0] <= gf_mult(g[0], fb).
  - Output register <= d, m_tvalid <= 1, m_tlast <= 0. Latency input→output is 1 cycle.
  - msg_cnt increments. On msg_cnt == K_LEN-1, msg_cnt clears and state → PARITY.
- Framing check: err_tlast pulses one cycle when s_tlast = 1 with msg_cnt != K_LEN-1, or s_tlast = 0 with msg_cnt == K_LEN-1.
  - Framing follows the counter only; s_tlast never alters state.
- PARITY state, each time the output register is free:
  - Output register <= par[ROOTS_NUM-1], m_tvalid <= 1.
  - par shifts up (par[i] <= par[i-1], par[0] <= 0); par_cnt increments.
  - On par_cnt == ROOTS_NUM-1: m_tlast <= 1, par_cnt clears, state → MSG.
  - par is all-zero on exit, ready for the next codeword.
- Throughput: without backpressure, N_LEN output symbols per codeword; the input stalls ROOTS_NUM cycles per codeword. The first message symbol of the next codeword may be accepted in the same cycle the last parity symbol is consumed.
- Output without handshake: no output symbol ever changes while m_tvalid && !m_tready; m_tdata and m_tlast are held.
- Output register clear: when consumed with no new load, m_tvalid <= 0; m_tdata keeps its value.
- Reset mid-codeword: all state is discarded and the next accepted symbol starts a fresh codeword.
- Arithmetic: all multiplies are GF(2^SYMB_WIDTH) using constant g[i]. The implementation synthesises constant multipliers; no run-time tables.

Test Plan:
- All-zero message, (255,239) → 239 zero symbols then 16 zero parity symbols; m_tlast only on output #255; err_tlast never asserts.
- Override N_LEN = 6, K_LEN = 4, FIRST_ROOT = 1 (g = x² + 6x + 8). Message [0,0,0,1] → output 0,0,0,1,6,8. Message [1,0,0,0] → parity equals x^5 mod g, checked against gf_pkg model.
- Random messages, (255,239): every output codeword evaluates to 0 at α^1..α^16 (gf_poly_eval model), and decodes error-free through rs decoder loopback.
- m_tready random 30% duty and s_tvalid random gaps → identical codeword stream to the no-stall run; m_tdata stable while stalled; no symbol lost or duplicated.
- s_tlast asserted on symbol #100 → err_tlast one pulse on that cycle; codeword still framed at 239/16.
- rst asserted at symbol #50 and at parity #5 → outputs cleared the next cycle; the following all-zero message yields all-zero parity.
